// File: rtl/oserdes_pkg.sv
// oserdes_tx shared types: FSM state, counter width helper and default idle word.
package oserdes_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam int unsigned OSERDES_DEF_DW    = 4;
  localparam int unsigned OSERDES_DEF_CNT_W = $clog2(OSERDES_DEF_DW);
  localparam logic [7:0]  OSERDES_DEF_TRAIN = 8'h0A;

  function automatic int unsigned cnt_w(input int unsigned dw);
    return (dw < 2) ? 1 : $clog2(dw);
  endfunction

endpackage

// File: rtl/oserdes_tx_shifter.sv
// Frame shift register and bit counter; OQ is SR[0], FSTART marks bit 0.
module oserdes_tx_shifter
  import oserdes_pkg::*;
#(
  parameter int unsigned DW = 4,
  parameter int unsigned CW = 2
) (
  input  logic          CLK0,
  input  logic          RST_N,
  input  logic          load_i,
  input  logic [DW-1:0] load_word_i,
  input  logic          shift_i,
  input  logic          clear_i,
  input  logic          run_i,
  output logic          oq_o,
  output logic          last_o,
  output logic          fstart_o
);

  logic [DW-1:0] sr_q, sr_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    sr_d  = sr_q;
    cnt_d = cnt_q;
    if (load_i) begin
      sr_d  = load_word_i;
      cnt_d = '0;
    end else if (clear_i) begin
      sr_d  = '0;
      cnt_d = '0;
    end else if (shift_i) begin
      sr_d  = sr_q >> 1;
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge CLK0 or negedge RST_N) begin
    if (!RST_N) begin
      sr_q  <= '0;
      cnt_q <= '0;
    end else begin
      sr_q  <= sr_d;
      cnt_q <= cnt_d;
    end
  end

  assign oq_o     = sr_q[0];
  assign last_o   = (cnt_q == CW'(DW - 1));
  assign fstart_o = run_i && (cnt_q == '0);

endmodule

// File: rtl/oserdes_tx.sv
// Parallel-to-serial transmitter, LSB first, training fill when starved.
// Optional OSERDES_TX_STATS_EN adds a saturating UNDERFLOW counter.
module oserdes_tx
  import oserdes_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = OSERDES_DEF_DW,
  parameter logic [7:0]  TRAIN_PATTERN = OSERDES_DEF_TRAIN
) (
  input  logic                  CLK0,
  input  logic                  RST_N,
  input  logic                  EN,
  input  logic [DATA_WIDTH-1:0] D,
  input  logic                  DVALID,
  output logic                  DREADY,
  output logic                  OQ,
  output logic                  FSTART,
  output logic                  UNDERFLOW
`ifdef OSERDES_TX_STATS_EN
  ,
  input  logic                  STATS_CLR,
  output logic [15:0]           UNDERFLOW_CNT
`endif
);

  localparam int unsigned CW = cnt_w(DATA_WIDTH);

  state_e state_q, state_d;
  logic                  hv_q, hv_d;
  logic [DATA_WIDTH-1:0] hold_q, hold_d;
  logic                  uf_q, uf_d;

  logic                  load, shift, clear;
  logic                  accept, sh_last;
  logic [DATA_WIDTH-1:0] load_word;

  assign accept    = DVALID && !hv_q;
  assign load_word = hv_q ? hold_q : TRAIN_PATTERN[DATA_WIDTH-1:0];

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    shift   = 1'b0;
    clear   = 1'b0;
    uf_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (EN) begin
          load    = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        if (!sh_last) begin
          shift = 1'b1;
        end else if (EN) begin
          load = 1'b1;
          uf_d = !hv_q;
        end else begin
          clear   = 1'b1;
          state_d = IDLE;
        end
      end
    endcase
  end

  // A load only consumes HOLD when it is full, so it never races an accept.
  always_comb begin
    hv_d   = hv_q;
    hold_d = hold_q;
    if (load && hv_q) begin
      hv_d = 1'b0;
    end else if (accept) begin
      hv_d   = 1'b1;
      hold_d = D;
    end
  end

  always_ff @(posedge CLK0 or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      hv_q    <= 1'b0;
      hold_q  <= '0;
      uf_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      hv_q    <= hv_d;
      hold_q  <= hold_d;
      uf_q    <= uf_d;
    end
  end

  oserdes_tx_shifter #(
    .DW (DATA_WIDTH),
    .CW (CW)
  ) u_shifter (
    .CLK0        (CLK0),
    .RST_N       (RST_N),
    .load_i      (load),
    .load_word_i (load_word),
    .shift_i     (shift),
    .clear_i     (clear),
    .run_i       (state_q == RUN),
    .oq_o        (OQ),
    .last_o      (sh_last),
    .fstart_o    (FSTART)
  );

  assign DREADY    = !hv_q;
  assign UNDERFLOW = uf_q;

`ifdef OSERDES_TX_STATS_EN
  logic [15:0] ucnt_q, ucnt_d;

  always_comb begin
    ucnt_d = ucnt_q;
    if (STATS_CLR) begin
      ucnt_d = '0;
    end else if (uf_q && (ucnt_q != 16'hFFFF)) begin
      ucnt_d = ucnt_q + 16'd1;
    end
  end

  always_ff @(posedge CLK0 or negedge RST_N) begin
    if (!RST_N) begin
      ucnt_q <= '0;
    end else begin
      ucnt_q <= ucnt_d;
    end
  end

  assign UNDERFLOW_CNT = ucnt_q;
`else
  // No statistics hardware in this build.
`endif

endmodule

// File: tb/tb_oserdes_tx.sv
// Randomized and directed bench for oserdes_tx against a frame-level model.
module tb_oserdes_tx;

  localparam int DW = 4;
  localparam logic [7:0] TP = 8'h0A;

  logic          CLK0 = 1'b0;
  logic          RST_N;
  logic          EN = 1'b0;
  logic [DW-1:0] D = '0;
  logic          DVALID = 1'b0;
  logic          DREADY, OQ, FSTART, UNDERFLOW;
`ifdef OSERDES_TX_STATS_EN
  logic          STATS_CLR = 1'b0;
  logic [15:0]   UNDERFLOW_CNT;
`endif

  oserdes_tx dut (
    .CLK0      (CLK0),
    .RST_N     (RST_N),
    .EN        (EN),
    .D         (D),
    .DVALID    (DVALID),
    .DREADY    (DREADY),
    .OQ        (OQ),
    .FSTART    (FSTART),
    .UNDERFLOW (UNDERFLOW)
`ifdef OSERDES_TX_STATS_EN
    ,
    .STATS_CLR     (STATS_CLR),
    .UNDERFLOW_CNT (UNDERFLOW_CNT)
`endif
  );

  always #5 CLK0 = ~CLK0;

  int errs = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [15:0] got,
                     input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Frame-level model: current frame word and bit index, one held word.
  bit          m_run;
  int          m_pos;
  logic [DW-1:0] m_frame, m_hold;
  bit          m_hv, m_uf;
  int          m_ucnt;

  task automatic model_reset();
    m_run = 0; m_pos = 0; m_frame = '0; m_hold = '0;
    m_hv = 0; m_uf = 0; m_ucnt = 0;
  endtask

  task automatic model_edge(input bit en, input bit dv,
                            input logic [DW-1:0] d, input bit clr);
    logic [7:0] tpv;
    bit hv0, endf, ld;
    tpv  = TP;
    hv0  = m_hv;
    endf = m_run && (m_pos == DW - 1);
    ld   = en && (!m_run || endf);
    if (clr) m_ucnt = 0;
    else if (m_uf && m_ucnt < 65535) m_ucnt++;
    m_uf = ld && m_run && !hv0;
    if (ld) begin
      m_frame = hv0 ? m_hold : tpv[DW-1:0];
      m_pos   = 0;
      m_run   = 1;
      if (hv0) m_hv = 0;
    end else if (m_run) begin
      if (endf) m_run = 0;
      else m_pos++;
    end
    if (dv && !hv0) begin
      m_hv   = 1;
      m_hold = d;
    end
  endtask

  task automatic check_outs(input string ph);
    chk({ph, ".oq"}, 16'(OQ), 16'(m_run ? m_frame[m_pos] : 1'b0));
    chk({ph, ".fstart"}, 16'(FSTART), 16'(m_run && m_pos == 0));
    chk({ph, ".uf"}, 16'(UNDERFLOW), 16'(m_uf));
    chk({ph, ".dready"}, 16'(DREADY), 16'(!m_hv));
`ifdef OSERDES_TX_STATS_EN
    chk({ph, ".ucnt"}, UNDERFLOW_CNT, 16'(m_ucnt));
`endif
  endtask

  task automatic cycle(input string ph, input bit en, input bit dv,
                       input logic [DW-1:0] d, input bit clr = 0);
    EN = en; DVALID = dv; D = d;
`ifdef OSERDES_TX_STATS_EN
    STATS_CLR = clr;
`endif
    @(posedge CLK0);
    model_edge(en, dv, d, clr);
    #1;
    check_outs(ph);
  endtask

  logic [3:0]  v4, f4;
  logic [11:0] v12;
  logic [15:0] v16, f16, u16;
  int          cnt_a, cnt_b, idx;
  logic [DW-1:0] words [3];
  bit          acc;

  initial begin
    RST_N = 1'b1;
    #2 RST_N = 1'b0;
    model_reset();
    #1;
    check_outs("reset");
    repeat (2) @(posedge CLK0);
    @(negedge CLK0);
    RST_N = 1'b1;

    // Single word 4'hB from IDLE
    cycle("sw_acc", 0, 1, 4'hB);
    for (int k = 0; k < 4; k++) begin
      cycle("sw", 1, 0, '0);
      v4[k] = OQ; f4[k] = FSTART;
    end
    chk("sw_oq_bits", 16'(v4), 16'hB);
    chk("sw_fstart", 16'(f4), 16'h1);
    cnt_a = 0;
    for (int k = 0; k < 5; k++) begin
      cycle("sw_train", k == 0, 0, '0);
      cnt_a += int'(UNDERFLOW);
    end
    chk("sw_uf_once", 16'(cnt_a), 16'd1);

    // Back-to-back words 1,2,3
    words[0] = 4'h1; words[1] = 4'h2; words[2] = 4'h3;
    cycle("b2b_acc", 0, 1, words[0]);
    idx = 1; cnt_a = 0; cnt_b = 0;
    for (int k = 0; k < 12; k++) begin
      acc = DREADY && (idx < 3);
      cycle("b2b", 1, idx < 3, (idx < 3) ? words[idx] : '0);
      if (acc) idx++;
      v12[k] = OQ;
      cnt_a += int'(UNDERFLOW);
      cnt_b += int'(!DREADY);
    end
    chk("b2b_oq_bits", 16'(v12), 16'h321);
    chk("b2b_uf_none", 16'(cnt_a), 16'd0);
    chk("b2b_dready_low", 16'(cnt_b), 16'd6);
    cycle("b2b_stop", 0, 0, '0);
    cycle("idle", 0, 0, '0);

    // Starvation: training frames
    cycle("st_clr", 0, 0, '0, 1);
    for (int k = 0; k < 16; k++) begin
      cycle("starve", 1, 0, '0, k == 13);
      v16[k] = OQ; f16[k] = FSTART; u16[k] = UNDERFLOW;
`ifdef OSERDES_TX_STATS_EN
      if (k == 11) chk("st_ucnt2", UNDERFLOW_CNT, 16'd2);
      if (k == 13) chk("st_ucnt_clr", UNDERFLOW_CNT, 16'd0);
`endif
    end
    chk("st_oq", v16, 16'hAAAA);
    chk("st_fstart", f16, 16'h1111);
    chk("st_uf", u16, 16'h1110);
    repeat (2) cycle("st_stop", 0, 0, '0);

    // EN drop at CNT=1, then held word sent first
    cycle("drop_acc", 0, 1, 4'h6);
    cycle("drop_ld", 1, 0, '0);
    cycle("drop_c1", 1, 0, '0);
    cycle("drop_c2", 0, 0, '0);
    chk("drop_bit2", 16'(OQ), 16'(1'b1));
    cycle("drop_c3", 0, 0, '0);
    chk("drop_bit3", 16'(OQ), 16'(1'b0));
    cycle("drop_idle", 0, 1, 4'h9);
    chk("drop_oq_idle", 16'(OQ), 16'(1'b0));
    chk("drop_dready", 16'(DREADY), 16'(1'b0));
    cycle("drop_idle2", 0, 0, '0);
    for (int k = 0; k < 4; k++) begin
      cycle("drop_resume", 1, 0, '0);
      v4[k] = OQ; f4[k] = FSTART;
    end
    chk("drop_held_bits", 16'(v4), 16'h9);
    chk("drop_held_fs", 16'(f4), 16'h1);
    cycle("drop_end", 0, 0, '0);

    // Reset mid-frame at CNT=2 with a word held
    cycle("rst_acc", 0, 1, 4'h4);
    cycle("rst_ld", 1, 0, '0);
    cycle("rst_c1", 1, 1, 4'h7);
    cycle("rst_c2", 1, 0, '0);
    chk("rst_pre_oq", 16'(OQ), 16'(1'b1));
    #2 RST_N = 1'b0;
    #1;
    model_reset();
    check_outs("rst_async");
    EN = 1'b0; DVALID = 1'b0;
    @(negedge CLK0);
    RST_N = 1'b1;
    repeat (4) cycle("rst_after", 0, 0, '0);

    // Randomized traffic
    for (int k = 0; k < 400; k++) begin
      cycle("rand", ($urandom % 8) != 0, $urandom % 2,
            DW'($urandom), ($urandom % 32) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
